// File: rtl/tug_field.sv
// tug_field: tug-of-war playfield with edge-detected players, one-hot light, round wins and scoring.
// Define TUG_DEBOUNCE_EN to debounce the synchronized human key over DEBOUNCE_CYCLES cycles.
module tug_field #(
  parameter int NUM_LEDS        = 9,
  parameter int SCORE_W         = 3,
  parameter int HOLD_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                human_raw,
  input  logic                cpu_press,
  output logic [NUM_LEDS-1:0] leds,
  output logic [SCORE_W-1:0]  human_score,
  output logic [SCORE_W-1:0]  cpu_score,
  output logic [1:0]          winner,
  output logic                round_over
);
  localparam logic [NUM_LEDS-1:0] CENTER = NUM_LEDS'(1) << ((NUM_LEDS - 1) / 2);
  localparam logic [SCORE_W-1:0]  LAST_BEFORE_MAX = SCORE_W'((1 << SCORE_W) - 2);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {PLAY, HOLD, GAME_OVER} state_t;
  state_t state, state_n;
  logic s1, s2, s3, cpu_prev, lvl, h_edge, c_edge, ro_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [NUM_LEDS-1:0] leds_n;
  logic [SCORE_W-1:0] hs_n, cs_n;
  logic [1:0] win_n;
`ifdef TUG_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] db_cnt;
  always_ff @(posedge clk)
    if (reset) db_cnt <= '0;
    else db_cnt <= !s2 ? '0 : db_cnt == DW'(DEBOUNCE_CYCLES - 1) ? db_cnt : db_cnt + 1'b1;
  // level rises on the DEBOUNCE_CYCLES-th consecutive high of s2, falls with s2
  assign lvl = s2 && db_cnt == DW'(DEBOUNCE_CYCLES - 1);
`else
  assign lvl = s2;
`endif
  assign h_edge = lvl & ~s3;
  assign c_edge = cpu_press & ~cpu_prev;
  always_ff @(posedge clk)
    if (reset) {s1, s2, s3, cpu_prev} <= '0;
    else {s1, s2, s3, cpu_prev} <= {human_raw, s1, lvl, cpu_press};
  always_comb begin
    state_n = state;
    leds_n  = leds;
    hs_n    = human_score;
    cs_n    = cpu_score;
    win_n   = winner;
    ro_n    = round_over;
    hold_n  = hold_cnt;
    if (state == PLAY && (h_edge ^ c_edge)) begin
      if (h_edge && leds[0]) begin
        hs_n    = human_score + 1'b1;
        win_n   = 2'b01;
        ro_n    = 1'b1;
        hold_n  = HW'(HOLD_CYCLES - 1);
        state_n = human_score == LAST_BEFORE_MAX ? GAME_OVER : HOLD;
      end else if (c_edge && leds[NUM_LEDS-1]) begin
        cs_n    = cpu_score + 1'b1;
        win_n   = 2'b10;
        ro_n    = 1'b1;
        hold_n  = HW'(HOLD_CYCLES - 1);
        state_n = cpu_score == LAST_BEFORE_MAX ? GAME_OVER : HOLD;
      end else
        leds_n = h_edge ? leds >> 1 : leds << 1;
    end else if (state == HOLD) begin
      if (hold_cnt == '0) begin
        leds_n  = CENTER;
        ro_n    = 1'b0;
        state_n = PLAY;
      end else
        hold_n = hold_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state       <= PLAY;
      leds        <= CENTER;
      human_score <= '0;
      cpu_score   <= '0;
      winner      <= 2'b00;
      round_over  <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      leds        <= leds_n;
      human_score <= hs_n;
      cpu_score   <= cs_n;
      winner      <= win_n;
      round_over  <= ro_n;
      hold_cnt    <= hold_n;
    end
endmodule

// File: doc/tug_field.md
Name: tug_field

Overview:
- Tug-of-war playfield stage. Sits directly downstream of the registered A>B comparator.
- The comparator's registered output acts as the CPU player's "press". A human key acts as the opponent.
- The block edge-detects both players, moves a one-hot light across an LED bar, detects round wins, keeps saturating per-player scores and ends the game at max score.

Parameters:
- NUM_LEDS, 9, LED bar length. Must be odd and ≥3. Centre index is (NUM_LEDS-1)/2.
- SCORE_W, 3, score counter width. Game ends when a score reaches 2^SCORE_W-1.
- HOLD_CYCLES, 4, cycles the win indication is held before the light re-centres.
- DEBOUNCE_CYCLES, 8, stable-high cycles required on human_raw. Used only with TUG_DEBOUNCE_EN.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- human_raw, input, 1: human key, active-high, asynchronous to clk.
- cpu_press, input, 1: registered comparator result. May stay high for many cycles.
- leds, output, NUM_LEDS: one-hot light position. Index 0 is the human end; index NUM_LEDS-1 is the CPU end.
- human_score, output, SCORE_W: rounds won by human.
- cpu_score, output, SCORE_W: rounds won by CPU.
- winner, output, 2: 00 none, 01 human, 10 CPU. Holds the last round winner.
- round_over, output, 1: high during HOLD and GAME_OVER.

Behaviour:
- Reset values (all outputs registered):
  - leds = one-hot at centre.
  - Both scores 0, winner 00, round_over 0.
  - Sync/edge flops 0; state PLAY.
  - Hold counter 0.
- Human path:
  - 2-flop synchronizer (s1, s2), then s3 for edge detect.
  - h_edge = s2 & ~s3.
  - If human_raw is first sampled high at edge k, h_edge is high for one cycle and acts at edge k+2.
- CPU path:
  - c_edge = cpu_press & ~cpu_prev, with cpu_prev registered.
  - Acts at the first edge where cpu_press is sampled high.
  - A level held high yields exactly one edge.
- States: PLAY, HOLD, GAME_OVER.
- PLAY moves:
  - h_edge alone: pos>0 → pos-1. pos==0 → human wins round.
  - c_edge alone: pos<NUM_LEDS-1 → pos+1. pos==NUM_LEDS-1 → CPU wins round.
  - h_edge & c_edge in same cycle: cancel, no move, no win.
- Round win, same edge:
  - Winner's score +1; winner set; round_over=1; hold counter loaded with HOLD_CYCLES-1; leds unchanged (light stays at end).
  - If the incremented score equals 2^SCORE_W-1: go to GAME_OVER, else HOLD.
- HOLD:
  - Both edges ignored. Counter decrements each cycle.
  - At counter 0: leds re-centre, round_over=0, state PLAY. winner keeps its value.
  - round_over is high for exactly HOLD_CYCLES cycles.
- GAME_OVER:
  - All outputs frozen and all edges ignored until reset.
- Scores saturate and never wrap, since GAME_OVER prevents further increments.
- Edge flops update in every state. A press started during HOLD does not fire when PLAY resumes unless it is re-pressed.
- Reset in any state, including mid-HOLD, returns everything to reset values on that edge.

Optional Feature:
- Macro TUG_DEBOUNCE_EN.
- When defined: s2 feeds a debounce counter. The debounced level goes high only after s2 has been 1 for DEBOUNCE_CYCLES consecutive cycles, and goes low immediately when s2=0. h_edge is taken from the debounced level, adding DEBOUNCE_CYCLES-1 cycles of latency. Glitches shorter than DEBOUNCE_CYCLES produce no move.
- When undefined: plain 2-flop sync, no counter logic, latency as above.

Test Plan:
- Defaults NUM_LEDS=9, SCORE_W=3, HOLD_CYCLES=4.
- Reset: hold reset 2 cycles → leds=9'b000010000, scores 0, winner 00, round_over 0.
- Human level: human_raw high for 10 cycles → exactly one move, leds=9'b000001000, at 2nd edge after first sample.
- CPU round win: 5 separate one-cycle cpu_press pulses.
  - After 4 pulses, leds=9'b100000000.
  - 5th pulse → cpu_score=1, winner=10, round_over=1 for exactly 4 cycles, then leds=9'b000010000.
- Simultaneous: cpu_press and human pulses aligned so c_edge and h_edge coincide → leds unchanged at centre.
- Game over: 7 human round wins → human_score=7, GAME_OVER. Further presses leave all outputs frozen; reset restores defaults.
- Reset mid-HOLD, and debounce: reset asserted during HOLD → defaults next edge. With TUG_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a 5-cycle human pulse → no move, a 12-cycle pulse → one move.
